// File: rtl/gmem_interconnect_pkg.sv
// Shared widths and defaults for the global-memory interconnect.
package gmem_interconnect_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int DEV_AW   = 10;
    localparam int PREFIX_W = ADDR_W - DEV_AW;

    localparam logic [PREFIX_W-1:0] DEV_PREFIX_DEFAULT = 6'b111111;

endpackage

// File: rtl/gmem_interconnect_rr_arbiter.sv
// One-hot grant arbiter: request-driven round-robin, or a rotating static slot
// when STATIC_ARBITRATION_EN is defined.
module rr_arbiter #(
    parameter int NUM_CORES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] request,
    output logic [NUM_CORES-1:0] grant_oh
);

    localparam int IW = $clog2(NUM_CORES);

`ifdef STATIC_ARBITRATION_EN
    logic [NUM_CORES-1:0] slot;
    logic                 unused_request;

    // The slot owner gets the grant whether or not it asks; the top gates the access.
    assign unused_request = ^request;
    assign grant_oh       = slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            slot <= NUM_CORES'(1);
        else
            slot <= {slot[NUM_CORES-2:0], slot[NUM_CORES-1]};
    end
`else
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic [IW:0]   cand;

    // Scan from the farthest candidate back to ptr so the closest requester wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_CORES))
                cand = cand - (IW+1)'(NUM_CORES);
            if (request[cand[IW-1:0]]) begin
                grant_idx = cand[IW-1:0];
                grant_any = 1'b1;
            end
        end
        if (grant_any)
            grant_oh[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (grant_any)
            ptr <= (grant_idx == IW'(NUM_CORES - 1)) ? '0 : grant_idx + IW'(1);
    end
`endif

endmodule

// File: rtl/gmem_interconnect.sv
// Single-port global memory / device interconnect for NUM_CORES cores.
// Optional STATIC_ARBITRATION_EN selects time-slot arbitration instead of round-robin.
module gmem_interconnect
    import gmem_interconnect_pkg::*;
#(
    parameter int                   NUM_CORES  = 8,
    parameter int                   GMEM_AW    = 10,
    parameter logic [PREFIX_W-1:0]  DEV_PREFIX = DEV_PREFIX_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_wren,
    input  logic [ADDR_W*NUM_CORES-1:0]   core_addr,
    input  logic [DATA_W*NUM_CORES-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_grant,
    output logic [NUM_CORES-1:0]          core_rvalid,
    output logic [DATA_W-1:0]             core_rdata,
    output logic [GMEM_AW-1:0]            gmem_addr,
    output logic                          gmem_we,
    output logic [DATA_W-1:0]             gmem_wdata,
    input  logic [DATA_W-1:0]             gmem_q,
    output logic [$clog2(NUM_CORES)-1:0]  dev_core_id,
    output logic                          dev_wren,
    output logic                          dev_rden,
    output logic [DEV_AW-1:0]             dev_addr,
    output logic [DATA_W-1:0]             dev_wdata,
    input  logic [DATA_W-1:0]             dev_rdata
);

    localparam int IW = $clog2(NUM_CORES);

    logic [IW-1:0]        gidx;
    logic                 issue;
    logic                 sel_wren;
    logic                 is_dev;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [NUM_CORES-1:0] rvalid_p1;
    logic                 dev_sel_p1;

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .request  (core_req),
        .grant_oh (core_grant)
    );

    // With no grant gidx stays 0, so the address/data buses show core 0.
    always_comb begin
        gidx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--)
            if (core_grant[i])
                gidx = IW'(i);
    end

    assign issue     = |(core_grant & core_req);
    assign sel_wren  = core_wren[gidx];
    assign sel_addr  = core_addr[32'(gidx)*ADDR_W +: ADDR_W];
    assign sel_wdata = core_wdata[32'(gidx)*DATA_W +: DATA_W];
    assign is_dev    = (sel_addr[ADDR_W-1:DEV_AW] == DEV_PREFIX);

    assign gmem_addr   = sel_addr[GMEM_AW-1:0];
    assign gmem_wdata  = sel_wdata;
    assign gmem_we     = issue & sel_wren & ~is_dev;
    assign dev_core_id = gidx;
    assign dev_addr    = sel_addr[DEV_AW-1:0];
    assign dev_wdata   = sel_wdata;
    assign dev_wren    = issue & sel_wren & is_dev;
    assign dev_rden    = issue & ~sel_wren & is_dev;

    // p1: read-return stage, aligned with the 1-cycle memory/device latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_p1  <= '0;
            dev_sel_p1 <= 1'b0;
        end else begin
            rvalid_p1 <= (issue & ~sel_wren) ? core_grant : '0;
            if (issue & ~sel_wren)
                dev_sel_p1 <= is_dev;
        end
    end

    assign core_rvalid = rvalid_p1;
    assign core_rdata  = dev_sel_p1 ? dev_rdata : gmem_q;

endmodule

// File: tb/tb_gmem_interconnect.sv
// Randomized bench for gmem_interconnect (NUM_CORES=4) with a behavioural model.
module tb_gmem_interconnect;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_req, core_wren, core_grant, core_rvalid;
    logic [16*N-1:0] core_addr, core_wdata;
    logic [15:0]     core_rdata, gmem_wdata, gmem_q, dev_wdata, dev_rdata;
    logic [9:0]      gmem_addr, dev_addr;
    logic            gmem_we, dev_wren, dev_rden;
    logic [1:0]      dev_core_id;

    gmem_interconnect #(.NUM_CORES(N), .GMEM_AW(10)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_wren(core_wren),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_grant(core_grant), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .gmem_addr(gmem_addr), .gmem_we(gmem_we), .gmem_wdata(gmem_wdata), .gmem_q(gmem_q),
        .dev_core_id(dev_core_id), .dev_wren(dev_wren), .dev_rden(dev_rden),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata)
    );

    always #5 clk = ~clk;

    // Environment: memory and device attached to the DUT
    bit [15:0] env_gmem [1024];
    bit [15:0] env_dev  [1024];

    always @(posedge clk) begin
        if (gmem_we) env_gmem[gmem_addr] <= gmem_wdata;
        gmem_q <= env_gmem[gmem_addr];
        if (dev_wren) env_dev[dev_addr] <= dev_wdata;
        dev_rdata <= env_dev[dev_addr];
    end

    // Behavioural model state
    bit [15:0] m_gmem [1024];
    bit [15:0] m_dev  [1024];
    int        m_ptr, m_slot, m_pend_core;
    bit        m_pend;
    bit [15:0] m_pend_data;

    // Held requests per core
    bit        r_v [N];
    bit        r_w [N];
    bit [15:0] r_a [N];
    bit [15:0] r_d [N];

    bit e_issue;
    int e_g;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            core_req[i]             = r_v[i];
            core_wren[i]            = r_w[i];
            core_addr[16*i +: 16]   = r_a[i];
            core_wdata[16*i +: 16]  = r_d[i];
        end
    endtask

    task automatic apply_and_check();
        logic [3:0]  exp_grant;
        logic [15:0] a;
        bit          wr, dev;
        drive();
        #1;
        e_issue = 1'b0;
        e_g     = 0;
`ifdef STATIC_ARBITRATION_EN
        e_g       = m_slot;
        e_issue   = r_v[m_slot];
        exp_grant = 4'(1 << m_slot);
`else
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!e_issue && r_v[i]) begin
                e_issue = 1'b1;
                e_g     = i;
            end
        end
        exp_grant = e_issue ? 4'(1 << e_g) : 4'b0;
`endif
        a   = r_a[e_g];
        wr  = r_w[e_g];
        dev = (a[15:10] == 6'h3F);
        chk("core_grant", 32'(core_grant), 32'(exp_grant));
        chk("gmem_we",  32'(gmem_we),  32'(e_issue && wr && !dev));
        chk("dev_wren", 32'(dev_wren), 32'(e_issue && wr && dev));
        chk("dev_rden", 32'(dev_rden), 32'(e_issue && !wr && dev));
        chk("gmem_addr",   32'(gmem_addr),   32'(a[9:0]));
        chk("dev_addr",    32'(dev_addr),    32'(a[9:0]));
        chk("dev_core_id", 32'(dev_core_id), 32'(e_g));
        if (e_issue && wr) begin
            chk("gmem_wdata", 32'(gmem_wdata), 32'(r_d[e_g]));
            chk("dev_wdata",  32'(dev_wdata),  32'(r_d[e_g]));
        end
        chk("core_rvalid", 32'(core_rvalid), m_pend ? 32'(1 << m_pend_core) : 32'd0);
        if (m_pend)
            chk("core_rdata", 32'(core_rdata), 32'(m_pend_data));
    endtask

    task automatic advance();
        bit [15:0] a;
        bit        dev;
        a      = r_a[e_g];
        dev    = (a[15:10] == 6'h3F);
        m_pend = 1'b0;
        if (e_issue) begin
            if (r_w[e_g]) begin
                if (dev) m_dev[a[9:0]] = r_d[e_g];
                else     m_gmem[a[9:0]] = r_d[e_g];
            end else begin
                m_pend      = 1'b1;
                m_pend_core = e_g;
                m_pend_data = dev ? m_dev[a[9:0]] : m_gmem[a[9:0]];
            end
            r_v[e_g] = 1'b0;
`ifndef STATIC_ARBITRATION_EN
            m_ptr = (e_g + 1) % N;
`endif
        end
`ifdef STATIC_ARBITRATION_EN
        m_slot = (m_slot + 1) % N;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) r_v[i] = 1'b0;
        drive();
        reset  = 1'b1;
        m_ptr  = 0;
        m_slot = 0;
        m_pend = 1'b0;
        repeat (2) @(negedge clk);
        #1;
`ifdef STATIC_ARBITRATION_EN
        chk("reset_grant", 32'(core_grant), 32'(4'b0001));
`else
        chk("reset_grant", 32'(core_grant), 32'(4'b0000));
`endif
        chk("reset_gmem_we",  32'(gmem_we),  32'd0);
        chk("reset_dev_wren", 32'(dev_wren), 32'd0);
        chk("reset_dev_rden", 32'(dev_rden), 32'd0);
        chk("reset_rvalid",   32'(core_rvalid), 32'd0);
        reset = 1'b0;
    endtask

    task automatic set_req(input int c, input bit w, input bit [15:0] a, input bit [15:0] d);
        r_v[c] = 1'b1; r_w[c] = w; r_a[c] = a; r_d[c] = d;
    endtask

    task automatic gen();
        for (int i = 0; i < N; i++) begin
            if (!r_v[i] && $urandom_range(0, 1) == 1) begin
                r_v[i] = 1'b1;
                r_w[i] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       r_a[i] = 16'($urandom_range(0, 15));
                    1:       r_a[i] = {6'($urandom_range(0, 62)), 10'($urandom_range(0, 15))};
                    default: r_a[i] = {6'h3F, 10'($urandom_range(0, 15))};
                endcase
                r_d[i] = 16'($urandom);
            end
        end
    endtask

    initial begin
        int exp_seq [5];
        exp_seq = '{1, 2, 4, 8, 1};
        for (int i = 0; i < N; i++) begin
            r_v[i] = 1'b0; r_w[i] = 1'b0; r_a[i] = 16'h0; r_d[i] = 16'h0;
        end
        reset = 1'b1;
        drive();
        @(negedge clk);
        do_reset();

`ifdef STATIC_ARBITRATION_EN
        set_req(2, 1'b1, 16'h0003, 16'h7777);
        for (int c = 0; c < N; c++) begin
            apply_and_check();
            chk("static_slot", 32'(core_grant), 32'(1 << c));
            chk("static_issue", 32'(gmem_we), 32'(c == 2));
            advance();
        end
`else
        // All four requesting: strict rotation from core 0
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'(i), 16'h0);
            apply_and_check();
            chk("rr_sequence", 32'(core_grant), 32'(exp_seq[c]));
            advance();
        end
        for (int i = 0; i < N; i++) r_v[i] = 1'b0;

        // Core 2 write then read of 0x0012
        set_req(2, 1'b1, 16'h0012, 16'hBEEF);
        apply_and_check();
        chk("wr_we", 32'(gmem_we), 32'd1);
        chk("wr_addr", 32'(gmem_addr), 32'h012);
        advance();
        set_req(2, 1'b0, 16'h0012, 16'h0);
        apply_and_check();
        advance();
        apply_and_check();
        chk("rd_rvalid", 32'(core_rvalid), 32'(4'b0100));
        chk("rd_rdata", 32'(core_rdata), 32'hBEEF);
        advance();

        // Aliased upper bits reach the same word
        set_req(0, 1'b1, 16'h0812, 16'h1357);
        apply_and_check();
        chk("alias_addr", 32'(gmem_addr), 32'h012);
        advance();
        set_req(3, 1'b0, 16'h0012, 16'h0);
        apply_and_check();
        advance();
        apply_and_check();
        chk("alias_rdata", 32'(core_rdata), 32'h1357);
        advance();

        // Device write then read through core 1
        set_req(1, 1'b1, 16'hFC05, 16'h1234);
        apply_and_check();
        chk("dev_wr", 32'(dev_wren), 32'd1);
        advance();
        set_req(1, 1'b0, 16'hFC05, 16'h0);
        apply_and_check();
        chk("dev_rden_lit", 32'(dev_rden), 32'd1);
        chk("dev_addr_lit", 32'(dev_addr), 32'h005);
        chk("dev_id_lit", 32'(dev_core_id), 32'd1);
        advance();
        apply_and_check();
        chk("dev_rvalid", 32'(core_rvalid), 32'(4'b0010));
        chk("dev_rdata", 32'(core_rdata), 32'h1234);
        advance();

        // Wrap: after core 3, core 0 comes first
        set_req(3, 1'b0, 16'h0001, 16'h0);
        apply_and_check();
        chk("wrap_g3", 32'(core_grant), 32'(4'b1000));
        advance();
        set_req(0, 1'b0, 16'h0002, 16'h0);
        set_req(3, 1'b0, 16'h0003, 16'h0);
        apply_and_check();
        chk("wrap_g0", 32'(core_grant), 32'(4'b0001));
        advance();
        apply_and_check();
        chk("wrap_g3b", 32'(core_grant), 32'(4'b1000));
        advance();

        // Reset between a read grant and its return drops the strobe
        set_req(0, 1'b0, 16'h0012, 16'h0);
        apply_and_check();
        chk("midread_grant", 32'(core_grant), 32'(4'b0001));
        do_reset();
        for (int c = 0; c < 2; c++) begin
            apply_and_check();
            chk("midread_norv", 32'(core_rvalid), 32'd0);
            advance();
        end
`endif

        for (int i = 0; i < N; i++) r_v[i] = 1'b0;
        repeat (400) begin
            gen();
            apply_and_check();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmem_interconnect.md
GMEM_INTERCONNECT -- requirements
Module: gmem_interconnect

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8, number of requesting cores (2..16).
REQ-002 SHALL have parameter GMEM_AW, default 10, global memory word-address width.
REQ-003 SHALL have parameter DEV_PREFIX, default 6'b111111, addr[15:10] value selecting device space.
REQ-004 SHALL use clock clk and reset reset (asynchronous, active-high).
REQ-005 Ports, in this order:
- clk  in  1  clock
- reset  in  1  async active-high reset
- core_req  in  NUM_CORES  access request per core, held until granted
- core_wren  in  NUM_CORES  1 = write, 0 = read
- core_addr  in  16*NUM_CORES  flattened word addresses, core i at [16i+15:16i]
- core_wdata  in  16*NUM_CORES  flattened write data
- core_grant  out  NUM_CORES  one-hot grant/ready, same cycle
- core_rvalid  out  NUM_CORES  one-hot read-return strobe
- core_rdata  out  16  shared read data, valid when any core_rvalid is set
- gmem_addr  out  GMEM_AW  global memory address
- gmem_we  out  1  global memory write enable
- gmem_wdata  out  16  global memory write data
- gmem_q  in  16  global memory read data, 1-cycle synchronous
- dev_core_id  out  $clog2(NUM_CORES)  granted core index
- dev_wren  out  1  device write strobe
- dev_rden  out  1  device read strobe
- dev_addr  out  10  device address (addr[9:0])
- dev_wdata  out  16  device write data
- dev_rdata  in  16  device read data, 1-cycle latency

Function
REQ-006 SHALL grant at most one core per cycle; core_grant is combinational from core_req and the arbitration state.
REQ-007 Granted access SHALL complete in the grant cycle: write to gmem when addr[15:10]!=DEV_PREFIX (gmem_we=1), else to device (dev_wren or dev_rden).
REQ-008 gmem_addr SHALL be addr[GMEM_AW-1:0] of the granted core; upper bits outside GMEM_AW and the prefix are ignored (aliasing).
REQ-009 For a granted read, core_rvalid[i] SHALL assert exactly one cycle after grant; core_rdata SHALL be dev_rdata if the registered device-select is set, else gmem_q.
REQ-010 With no grant: gmem_we, dev_wren, dev_rden SHALL be 0; dev_core_id, dev_addr, gmem_addr SHALL hold the lowest-indexed core's values (don't-care, no strobe).
REQ-011 Round-robin: the priority pointer SHALL advance to (granted index + 1) mod NUM_CORES only on a cycle with a grant; it is unchanged in idle cycles.
REQ-012 The core with index NUM_CORES-1 granted SHALL wrap priority to core 0.
REQ-013 A core requesting continuously SHALL be granted within NUM_CORES cycles (no starvation).
REQ-014 Back-to-back reads from different cores SHALL each produce a correctly routed rvalid one cycle after their grant, sustaining one access per cycle.
REQ-015 A write SHALL never assert core_rvalid.

Reset
REQ-016 On reset: priority pointer = core 0, rvalid register = 0, device-select register = 0, static slot = 1 (core 0).
REQ-017 Reset asserted mid-read SHALL suppress the pending core_rvalid; no strobe after reset deasserts until a new grant.

Configuration
REQ-018 Macro STATIC_ARBITRATION_EN defined: a one-hot slot register SHALL rotate left every cycle; core_grant = slot regardless of core_req; an access is issued only if core_req of the slot owner is 1.
REQ-019 STATIC_ARBITRATION_EN undefined: request-driven round-robin per REQ-011..REQ-013.

Structure
REQ-020 A shared package SHALL hold DEV_PREFIX default, the 16-bit data/address width constants and the device address width (10).
REQ-021 Arbitration SHALL be a sub-module rr_arbiter (request, grant_oh, clk, reset, parameter NUM_CORES); the static-slot variant lives inside it under the macro.

Verification (NUM_CORES=4, round-robin unless noted)
REQ-022 Reset, no requests -> core_grant=0, gmem_we=0, dev_wren=0, dev_rden=0, core_rvalid=0.
REQ-023 Core 2 writes 0xBEEF to 0x0012, then reads 0x0012 -> gmem_we pulse at gmem_addr=0x012; next read gives core_rvalid=4'b0100, core_rdata=0xBEEF.
REQ-024 All four request continuously -> grants 0,1,2,3,0 on consecutive cycles.
REQ-025 Core 1 reads 0xFC05 with dev_rdata=0x1234 -> dev_rden=1, dev_addr=0x005, dev_core_id=1; next cycle core_rvalid=4'b0010, core_rdata=0x1234.
REQ-026 Core 3 granted, then cores 0 and 3 request together -> core 0 granted first (wrap).
REQ-027 STATIC_ARBITRATION_EN, only core 2 requests from reset -> core_grant cycles 0001,0010,0100,1000; access issued only in the 0100 cycle.
